// File: rtl/hero_pkg.sv
// Shared types and default timing for the hero movement input path.
//   dir_t        : movement direction carried by axis requests
//   axis_state_t : per-axis press/repeat state machine states
package hero_pkg;

  typedef enum logic [2:0] {
    NONE  = 3'd0,
    LEFT  = 3'd1,
    RIGHT = 3'd2,
    UP    = 3'd3,
    DOWN  = 3'd4
  } dir_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FIRST  = 3'd1,
    DELAY  = 3'd2,
    REPEAT = 3'd3,
    HOLD   = 3'd4
  } axis_state_t;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 20;
  localparam int unsigned DEF_REPEAT_DELAY    = 400;
  localparam int unsigned DEF_REPEAT_RATE     = 100;
  localparam bit          DEF_REPEAT_EN       = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axis_repeat.sv
// Per-axis press / hold-to-repeat state machine producing step pulses.
//   clk_1      : game clock
//   rst        : asynchronous active-low reset
//   neg_i      : debounced level of the negative-direction button
//   pos_i      : debounced level of the positive-direction button
//   move_neg_o : one-cycle step pulse, negative direction (registered)
//   move_pos_o : one-cycle step pulse, positive direction (registered)
module axis_repeat
  import hero_pkg::*;
#(
  parameter int unsigned REPEAT_DELAY = 400,
  parameter int unsigned REPEAT_RATE  = 100,
  parameter bit          REPEAT_EN    = 1'b1,
  parameter dir_t        NEG_DIR      = LEFT,
  parameter dir_t        POS_DIR      = RIGHT
) (
  input  logic clk_1,
  input  logic rst,
  input  logic neg_i,
  input  logic pos_i,
  output logic move_neg_o,
  output logic move_pos_o
);

  localparam int unsigned CW = $clog2(max_u(REPEAT_DELAY, REPEAT_RATE) + 1);
  localparam logic [CW-1:0] DLY_C  = CW'(REPEAT_DELAY);
  localparam logic [CW-1:0] RATE_C = CW'(REPEAT_RATE);

  axis_state_t   state_q, state_d;
  dir_t          dir_q, dir_d;
  dir_t          req;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          neg_q, neg_d;
  logic          pos_q, pos_d;
  logic          pulse_c;

  // Both or neither pressed cancels the axis request.
  always_comb begin
    if (neg_i ^ pos_i) req = neg_i ? NEG_DIR : POS_DIR;
    else               req = NONE;
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    pulse_c = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (req != NONE) begin
          state_d = FIRST;
          dir_d   = req;
        end
      end
      FIRST: begin
        pulse_c = 1'b1;
        cnt_d   = CW'(1);
        state_d = REPEAT_EN ? DELAY : HOLD;
      end
      DELAY, REPEAT: begin
        if (req == NONE) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (req != dir_q) begin
          state_d = FIRST;
          dir_d   = req;
        end else if (cnt_q == ((state_q == DELAY) ? DLY_C : RATE_C)) begin
          pulse_c = 1'b1;
          state_d = REPEAT;
          cnt_d   = CW'(1);
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      HOLD: begin
        if (req == NONE) begin
          state_d = IDLE;
        end else if (req != dir_q) begin
          state_d = FIRST;
          dir_d   = req;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    neg_d = pulse_c && (dir_q == NEG_DIR);
    pos_d = pulse_c && (dir_q == POS_DIR);
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dir_q   <= NONE;
      cnt_q   <= '0;
      neg_q   <= 1'b0;
      pos_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
      pos_q   <= pos_d;
    end
  end

  assign move_neg_o = neg_q;
  assign move_pos_o = pos_q;

endmodule

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for one raw button.
//   clk_1   : game clock
//   rst     : asynchronous active-low reset
//   btn_i   : raw, bouncing, asynchronous button level
//   level_o : debounced level (registered)
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 20
) (
  input  logic clk_1,
  input  logic rst,
  input  logic btn_i,
  output logic level_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST_C = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter runs only while the synchronized input disagrees with the
  // stable level; the D-th disagreeing cycle flips the level.
  always_comb begin
    level_d = level_q;
    cnt_d   = cnt_q;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == LAST_C) begin
      level_d = sync2_q;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_1 or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/hero_key_encoder.sv
// Turns four raw direction buttons into clean single-cycle move pulses with
// conflict rejection and hold-to-repeat.
//   clk_1                    : divided game clock
//   rst                      : asynchronous active-low reset
//   btn_left/right/up/down   : raw active-high buttons
//   move_left/right/up/down  : one-cycle step pulses (registered)
module hero_key_encoder
  import hero_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_RATE     = DEF_REPEAT_RATE,
  parameter bit          REPEAT_EN       = DEF_REPEAT_EN
) (
  input  logic clk_1,
  input  logic rst,
  input  logic btn_left,
  input  logic btn_right,
  input  logic btn_up,
  input  logic btn_down,
  output logic move_left,
  output logic move_right,
  output logic move_up,
  output logic move_down
);

  logic lvl_left, lvl_right, lvl_up, lvl_down;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
    .clk_1(clk_1), .rst(rst), .btn_i(btn_left), .level_o(lvl_left)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
    .clk_1(clk_1), .rst(rst), .btn_i(btn_right), .level_o(lvl_right)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
    .clk_1(clk_1), .rst(rst), .btn_i(btn_up), .level_o(lvl_up)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
    .clk_1(clk_1), .rst(rst), .btn_i(btn_down), .level_o(lvl_down)
  );

  axis_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE),
    .REPEAT_EN(REPEAT_EN), .NEG_DIR(LEFT), .POS_DIR(RIGHT)
  ) u_axis_x (
    .clk_1(clk_1), .rst(rst), .neg_i(lvl_left), .pos_i(lvl_right),
    .move_neg_o(move_left), .move_pos_o(move_right)
  );

  axis_repeat #(
    .REPEAT_DELAY(REPEAT_DELAY), .REPEAT_RATE(REPEAT_RATE),
    .REPEAT_EN(REPEAT_EN), .NEG_DIR(UP), .POS_DIR(DOWN)
  ) u_axis_y (
    .clk_1(clk_1), .rst(rst), .neg_i(lvl_up), .pos_i(lvl_down),
    .move_neg_o(move_up), .move_pos_o(move_down)
  );

endmodule

// File: tb/tb_hero_key_encoder.sv
// Directed bench: DUT a has auto-repeat, DUT b has REPEAT_EN=0; both see the
// same buttons. Button vector bit order is {down, up, right, left}.
module tb_hero_key_encoder;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic btn_l = 1'b0, btn_r = 1'b1, btn_u = 1'b0, btn_d = 1'b0;
  logic a_l, a_r, a_u, a_d;
  logic b_l, b_r, b_u, b_d;

  int errors = 0;
  int checks = 0;
  int tot_a [4];
  int tot_b [4];
  int snap_a [4];
  int snap_b [4];

  typedef struct {
    logic [3:0]       btn;
    int unsigned      hold;
    logic [3:0][7:0]  exp_a;
    logic [3:0][7:0]  exp_b;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  hero_key_encoder #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .REPEAT_EN(1'b1)
  ) dut_a (
    .clk_1(clk), .rst(rst),
    .btn_left(btn_l), .btn_right(btn_r), .btn_up(btn_u), .btn_down(btn_d),
    .move_left(a_l), .move_right(a_r), .move_up(a_u), .move_down(a_d)
  );

  hero_key_encoder #(
    .DEBOUNCE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_RATE(3), .REPEAT_EN(1'b0)
  ) dut_b (
    .clk_1(clk), .rst(rst),
    .btn_left(btn_l), .btn_right(btn_r), .btn_up(btn_u), .btn_down(btn_d),
    .move_left(b_l), .move_right(b_r), .move_up(b_u), .move_down(b_d)
  );

  initial begin
    for (int i = 0; i < 4; i++) begin
      tot_a[i] = 0;
      tot_b[i] = 0;
    end
  end

  // Running pulse totals, sampled mid-cycle.
  always @(negedge clk) begin
    tot_a[0] <= tot_a[0] + int'(a_l);
    tot_a[1] <= tot_a[1] + int'(a_r);
    tot_a[2] <= tot_a[2] + int'(a_u);
    tot_a[3] <= tot_a[3] + int'(a_d);
    tot_b[0] <= tot_b[0] + int'(b_l);
    tot_b[1] <= tot_b[1] + int'(b_r);
    tot_b[2] <= tot_b[2] + int'(b_u);
    tot_b[3] <= tot_b[3] + int'(b_d);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_btn(input logic [3:0] b);
    {btn_d, btn_u, btn_r, btn_l} = b;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, int'({a_d, a_u, a_r, a_l}), 0);
    chk({tag, "_b"}, int'({b_d, b_u, b_r, b_l}), 0);
  endtask

  // Observes edges 0..10 after the next edge and expects a lone pulse after edge 7.
  task automatic chk_single_pulse(input string tag, input int idx);
    logic [3:0] o;
    for (int j = 0; j <= 10; j++) begin
      tick();
      o = {a_d, a_u, a_r, a_l};
      chk($sformatf("%s_e%0d", tag, j), int'(o[idx]), (j == 7) ? 1 : 0);
    end
  endtask

  initial begin
    vecs[0] = '{4'b0010, 1,  32'h00000000, 32'h00000000};
    vecs[1] = '{4'b0100, 3,  32'h00000000, 32'h00000000};
    vecs[2] = '{4'b0001, 30, 32'h00000008, 32'h00000001};
    vecs[3] = '{4'b0010, 4,  32'h00000100, 32'h00000100};
    vecs[4] = '{4'b0011, 20, 32'h00000000, 32'h00000000};
    vecs[5] = '{4'b0110, 14, 32'h00020200, 32'h00010100};
    vecs[6] = '{4'b1000, 50, 32'h0E000000, 32'h01000000};

    // Reset with btn_right held, then release: pulse after edge 7.
    repeat (3) tick();
    chk_all_zero("rst_hold");
    rst = 1'b1;
    chk_single_pulse("rst_rel_right", 1);
    set_btn(4'b0000);
    repeat (15) tick();

    // Reset asserted mid-hold kills pulses; a still-held button re-fires.
    set_btn(4'b0001);
    repeat (20) tick();
    rst = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    repeat (3) tick();
    chk_all_zero("rst_mid_hold");
    rst = 1'b1;
    chk_single_pulse("rst_mid_left", 0);
    set_btn(4'b0000);
    repeat (15) tick();

    // Table: hold pattern, release, settle; compare pulse counts per output.
    for (int v = 0; v < 7; v++) begin
      for (int i = 0; i < 4; i++) begin
        snap_a[i] = tot_a[i];
        snap_b[i] = tot_b[i];
      end
      set_btn(vecs[v].btn);
      repeat (vecs[v].hold) tick();
      set_btn(4'b0000);
      repeat (12) tick();
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("vec%0d_a_out%0d", v, i), tot_a[i] - snap_a[i], int'(vecs[v].exp_a[i]));
        chk($sformatf("vec%0d_b_out%0d", v, i), tot_b[i] - snap_b[i], int'(vecs[v].exp_b[i]));
      end
    end

    // Conflict then drop left: move_right exactly 7 edges after the drop.
    for (int i = 0; i < 4; i++) snap_a[i] = tot_a[i];
    set_btn(4'b0011);
    repeat (20) tick();
    chk("conflict_left", tot_a[0] - snap_a[0], 0);
    chk("conflict_right", tot_a[1] - snap_a[1], 0);
    set_btn(4'b0010);
    for (int j = 0; j <= 10; j++) begin
      tick();
      chk($sformatf("drop_right_e%0d", j), int'(a_r), (j == 7) ? 1 : 0);
      chk($sformatf("drop_left_e%0d", j), int'(a_l), 0);
    end
    set_btn(4'b0000);
    repeat (15) tick();

    // Diagonal press, then right->left swap mid-DELAY restarts the X timer.
    set_btn(4'b0110);
    for (int j = 0; j <= 30; j++) begin
      tick();
      chk($sformatf("diag_up_e%0d", j), int'(a_u),
          (j == 7 || j == 17 || j == 20 || j == 23 || j == 26 || j == 29) ? 1 : 0);
      chk($sformatf("swap_right_e%0d", j), int'(a_r), (j == 7) ? 1 : 0);
      chk($sformatf("swap_left_e%0d", j), int'(a_l),
          (j == 17 || j == 27 || j == 30) ? 1 : 0);
      if (j == 9) set_btn(4'b0101);
    end
    set_btn(4'b0000);
    repeat (15) tick();
    chk_all_zero("final_idle");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hero_key_encoder.md
# hero_key_encoder

Drives the hero's movement interface. Takes the four raw, bouncing direction buttons and turns them into clean, single-cycle move pulses (move_left/right/up/down) that the position tracker consumes as step commands. The block sits between the board button pins and the hero position logic, in the divided clk_1 domain. It debounces each button, rejects conflicting presses on an axis, and generates hold-to-repeat auto-stepping.

## Interface
- DEBOUNCE_CYCLES, 20: consecutive stable clk_1 cycles required before a button level change is accepted (≥1).
- REPEAT_DELAY, 400: clk_1 cycles from the first pulse to the first auto-repeat pulse (≥1).
- REPEAT_RATE, 100: clk_1 cycles between subsequent auto-repeat pulses (≥1).
- REPEAT_EN, 1: 0 disables auto-repeat, giving one pulse per press.
- clk_1  in  1  divided game clock; all logic on its rising edge.
- rst  in  1  asynchronous, active-low reset.
- btn_left  in  1  raw button, active-high, asynchronous to clk_1.
- btn_right  in  1  raw button, active-high.
- btn_up  in  1  raw button, active-high.
- btn_down  in  1  raw button, active-high.
- move_left  out  1  one-cycle step pulse.
- move_right  out  1  one-cycle step pulse.
- move_up  out  1  one-cycle step pulse.
- move_down  out  1  one-cycle step pulse.

## Operation
- **Input conditioning**
  - Each button passes through a 2-FF synchronizer, then a debouncer.
  - The debouncer holds a stable level and a counter. The counter increments while the synchronized value differs from the stable level, and clears when it matches.
  - On reaching DEBOUNCE_CYCLES, the stable level flips and the counter clears.
- **Axes**
  - Two independent axes: X (left/right) and Y (up/down). Each axis computes its request from its debounced pair.
  - Request is NONE when neither or both buttons of the pair are pressed. Otherwise it is the single pressed direction.
- **Per-axis FSM**
  - IDLE: request != NONE → FIRST, latching dir.
  - FIRST: pulse for dir asserted this cycle. Next state is DELAY if REPEAT_EN, else HOLD. The counter loads 1.
  - DELAY: counter increments. Request NONE → IDLE. Request != latched dir → FIRST with the new dir. Counter == REPEAT_DELAY → REPEAT, pulse asserted, counter loads 1.
  - REPEAT: same exits as DELAY. Counter == REPEAT_RATE → pulse asserted, counter loads 1.
  - HOLD: no pulses. Request NONE → IDLE. A different dir → FIRST.
- **Outputs**
  - Registered, driven only from FSM state/transition.
  - At most one pulse per axis per cycle. X and Y may pulse in the same cycle (diagonal).
- **Counter widths**
  - Debounce counter: $clog2(DEBOUNCE_CYCLES+1).
  - Repeat counter: $clog2(max(REPEAT_DELAY,REPEAT_RATE)+1).
  - Counters saturate, never wrap.

## Timing
- **Reset** (rst low, asynchronous):
  - All move_* outputs = 0.
  - Synchronizers and debounced levels = 0.
  - Counters = 0, both FSMs = IDLE.
  - Release is sampled synchronously.
  - Reset asserted mid-hold kills pulses immediately. After release, a still-held button is re-debounced and yields a fresh FIRST pulse.
- **Press latency:** raw high first sampled at edge k → move pulse high for exactly the one cycle following edge k+DEBOUNCE_CYCLES+3.
- **Release latency:** symmetric. Pulses stop no later than DEBOUNCE_CYCLES+3 edges after raw low.
- **Repeat spacing:** first pulse at cycle T, repeats at T+REPEAT_DELAY, then every REPEAT_RATE cycles while held.
- **Glitch rejection:** a bounce shorter than DEBOUNCE_CYCLES cycles produces no level change and no pulse.
- **Simultaneous events:**
  - Opposite buttons pressed together → no pulse.
  - Release one of the two → FIRST pulse for the remaining direction once debounced.
  - Direction swap in one cycle → immediate FIRST for the new dir; the repeat timer restarts.

## Structure
- Shared package hero_pkg holds:
  - dir_t (NONE, LEFT, RIGHT, UP, DOWN)
  - axis_state_t (IDLE, FIRST, DELAY, REPEAT, HOLD)
  - default timing constants
- Sub-module btn_debounce (synchronizer + debouncer, parameter DEBOUNCE_CYCLES), instantiated four times.
- The axis FSM is written once as axis_repeat and instantiated for X and Y.

## Test plan
Sims use DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_RATE=3.
- Reset: rst low with btn_right held → all outputs 0. Release rst at edge 0 → single move_right pulse after edge 7.
- Glitch: btn_up high for 3 cycles, then low → no move_up pulse ever.
- Auto-repeat: btn_left held 30 cycles → move_left pulses at T, T+10, T+13, T+16, T+19, … Exactly one pulse per event, none after release + 7 cycles.
- REPEAT_EN=0: btn_down held 50 cycles → exactly one move_down pulse.
- Conflict: btn_left and btn_right pressed the same cycle for 20 cycles → no X pulses. Drop btn_left → move_right pulse 7 edges later.
- Diagonal / swap: btn_up and btn_right pressed together → move_up and move_right pulse in the same cycle. Swap btn_right→btn_left in one cycle mid-DELAY → move_left FIRST pulse with no trailing move_right repeat.
